// File: rtl/edge_detector_mc_if.sv
// Pin-side bundle for the multi-channel edge detector: raw inputs and clears in,
// filtered level, strobes, pulses and flags out.
interface edge_detector_mc_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] signal;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] pulse;
    logic [WIDTH-1:0] flag;
    logic             any_pulse;

    // Consumer side: drives raw inputs and clears, observes events
    modport master (
        output signal, clr,
        input  level, rise, fall, pulse, flag, any_pulse
    );

    // Detector side
    modport slave (
        input  signal, clr,
        output level, rise, fall, pulse, flag, any_pulse
    );
endinterface

// File: rtl/edge_detector_mc.sv
// Multi-channel edge detector: per channel a synchroniser, a persistence filter,
// registered rise/fall strobes, a retriggerable stretched pulse and a sticky flag.
module edge_detector_mc #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 3,
    parameter int unsigned MODE          = 0,
    parameter int unsigned PULSE_LEN     = 1,
    parameter bit          INIT_LEVEL    = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    edge_detector_mc_if.slave  bus
);

    localparam int unsigned FCW = $clog2(FILTER_CYCLES + 1);
    localparam int unsigned PCW = $clog2(PULSE_LEN + 1);
    localparam logic [FCW-1:0] FILT_LAST  = FCW'(FILTER_CYCLES - 1);
    localparam logic [PCW-1:0] PULSE_LOAD = PCW'(PULSE_LEN - 1);

    // Reject configurations the datapath cannot honour
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("edge_detector_mc: SYNC_STAGES must be >= 2");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("edge_detector_mc: FILTER_CYCLES must be >= 1");
    end
    if (PULSE_LEN < 1) begin : g_bad_pulse
        $error("edge_detector_mc: PULSE_LEN must be >= 1");
    end
    if (MODE > 2) begin : g_bad_mode
        $error("edge_detector_mc: MODE must be 0, 1 or 2");
    end

    logic [WIDTH-1:0] pulse_vec;

    for (genvar ch = 0; ch < WIDTH; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s_c;
        logic [FCW-1:0]         fcnt_q, fcnt_d;
        logic [PCW-1:0]         pcnt_q, pcnt_d;
        logic                   level_q, level_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;
        logic                   pulse_q, pulse_d;
        logic                   flag_q, flag_d;
        logic                   sel_c;

        assign s_c = sync_q[SYNC_STAGES-1];

        // Metastability chain: shift raw input towards s_c
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= {SYNC_STAGES{INIT_LEVEL}};
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], bus.signal[ch]};
            end
        end

        // Filter commit, edge classification, pulse stretch and flag update
        always_comb begin
            level_d = level_q;
            fcnt_d  = fcnt_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            sel_c   = 1'b0;
            pulse_d = 1'b0;
            pcnt_d  = pcnt_q;
            flag_d  = flag_q;

            if (s_c == level_q) begin
                fcnt_d = '0;
            end else if (fcnt_q == FILT_LAST) begin
                level_d = s_c;
                fcnt_d  = '0;
                rise_d  = s_c;
                fall_d  = ~s_c;
            end else begin
                fcnt_d = fcnt_q + FCW'(1);
            end

            // Edge selection shares the commit condition, so no extra latency
            if (MODE == 0) begin
                sel_c = rise_d;
            end else if (MODE == 1) begin
                sel_c = fall_d;
            end else begin
                sel_c = rise_d | fall_d;
            end

            // A new edge reloads the full length, so merged pulses never shorten
            if (sel_c) begin
                pulse_d = 1'b1;
                pcnt_d  = PULSE_LOAD;
            end else if (pcnt_q != '0) begin
                pulse_d = 1'b1;
                pcnt_d  = pcnt_q - PCW'(1);
            end

            // Set wins over a coincident clear
            flag_d = sel_c | (flag_q & ~bus.clr[ch]);
        end

        // Channel state registers
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                level_q <= INIT_LEVEL;
                fcnt_q  <= '0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                pulse_q <= 1'b0;
                pcnt_q  <= '0;
                flag_q  <= 1'b0;
            end else begin
                level_q <= level_d;
                fcnt_q  <= fcnt_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
                pulse_q <= pulse_d;
                pcnt_q  <= pcnt_d;
                flag_q  <= flag_d;
            end
        end

        assign bus.level[ch] = level_q;
        assign bus.rise[ch]  = rise_q;
        assign bus.fall[ch]  = fall_q;
        assign bus.pulse[ch] = pulse_q;
        assign bus.flag[ch]  = flag_q;
        assign pulse_vec[ch] = pulse_q;
    end

    assign bus.any_pulse = |pulse_vec;

endmodule

// File: tb/tb_edge_detector_mc.sv
// Bench for edge_detector_mc: four instances (rising, falling, both edges with
// FILTER=3/PULSE=2, and both edges with FILTER=1/PULSE=8/INIT=1) driven by
// directed vectors; expectations are queued per cycle and checked by a monitor.
module tb_edge_detector_mc;

    localparam int unsigned W = 4;
    localparam int unsigned MODES [4] = '{0, 1, 2, 2};
    localparam int unsigned FILTS [4] = '{3, 3, 3, 1};
    localparam int unsigned PLENS [4] = '{2, 2, 2, 8};
    localparam bit          INITS [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    localparam int DA = 0, DB = 1, DC = 2, DD = 3;
    localparam int F_LVL = 0, F_RISE = 1, F_FALL = 2, F_PUL = 3, F_FLG = 4, F_ANY = 5;
    localparam int F_NRISE = 6, F_NFALL = 7, F_NPED = 8, F_NPHI = 9;

    typedef struct {
        int    cyc;
        int    dut;
        int    fld;
        int    val;
        int    msk;
        string name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    logic [W-1:0] sig_abc, clr_abc, sig_d, clr_d;
    logic [W-1:0] o_level [4];
    logic [W-1:0] o_rise  [4];
    logic [W-1:0] o_fall  [4];
    logic [W-1:0] o_pulse [4];
    logic [W-1:0] o_flag  [4];
    logic         o_any   [4];

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_rise [4];
    int   n_fall [4];
    int   n_ped  [4];
    int   n_phi  [4];
    logic prev_p [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    edge_detector_mc_if #(.WIDTH(W)) ifs [4] ();

    for (genvar g = 0; g < 4; g++) begin : g_dut
        assign ifs[g].signal = (g == 3) ? sig_d : sig_abc;
        assign ifs[g].clr    = (g == 3) ? clr_d : clr_abc;
        assign o_level[g] = ifs[g].level;
        assign o_rise[g]  = ifs[g].rise;
        assign o_fall[g]  = ifs[g].fall;
        assign o_pulse[g] = ifs[g].pulse;
        assign o_flag[g]  = ifs[g].flag;
        assign o_any[g]   = ifs[g].any_pulse;

        edge_detector_mc #(
            .WIDTH        (W),
            .SYNC_STAGES  (2),
            .FILTER_CYCLES(FILTS[g]),
            .MODE         (MODES[g]),
            .PULSE_LEN    (PLENS[g]),
            .INIT_LEVEL   (INITS[g])
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(ifs[g])
        );
    end

    function automatic int get_out(input int d, input int f);
        case (f)
            F_LVL:   return int'(o_level[d]);
            F_RISE:  return int'(o_rise[d]);
            F_FALL:  return int'(o_fall[d]);
            F_PUL:   return int'(o_pulse[d]);
            F_FLG:   return int'(o_flag[d]);
            F_ANY:   return int'(o_any[d]);
            F_NRISE: return n_rise[d];
            F_NFALL: return n_fall[d];
            F_NPED:  return n_ped[d];
            default: return n_phi[d];
        endcase
    endfunction

    // Monitor: tally channel-2 events, then retire every expectation due this cycle
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (o_rise[d][2] === 1'b1) n_rise[d]++;
            if (o_fall[d][2] === 1'b1) n_fall[d]++;
            if (o_pulse[d][2] === 1'b1) n_phi[d]++;
            if (o_pulse[d][2] === 1'b1 && prev_p[d] !== 1'b1) n_ped[d]++;
            prev_p[d] = o_pulse[d][2];
        end
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                int act;
                act = get_out(q[i].dut, q[i].fld) & q[i].msk;
                n_cmp++;
                if (q[i].cyc < cyc) begin
                    n_bad++;
                    $display("FAIL %s: expectation for cycle %0d missed (now %0d)",
                             q[i].name, q[i].cyc, cyc);
                end else if (act != (q[i].val & q[i].msk)) begin
                    n_bad++;
                    $display("FAIL %s: dut %0d cycle %0d got 0x%0h expected 0x%0h",
                             q[i].name, q[i].dut, cyc, act, q[i].val & q[i].msk);
                end
                q.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic ex(input int c, input int d, input int f, input int v, input int m,
                      input string nm);
        exp_t e;
        e = '{c, d, f, v, m, nm};
        q.push_back(e);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int d = 0; d < 4; d++) begin
            n_rise[d] = 0; n_fall[d] = 0; n_ped[d] = 0; n_phi[d] = 0; prev_p[d] = 1'b0;
        end
        rst     = 1'b1;
        sig_abc = '0;
        clr_abc = '0;
        sig_d   = 4'hF;
        clr_d   = '0;
        tick(3);
        rst = 1'b0;

        // Reset values, and INIT_LEVEL=1 instance quiet with inputs held high
        t = cyc;
        ex(t, DA, F_LVL, 0, 15, "rst_level");
        ex(t, DA, F_RISE, 0, 15, "rst_rise");
        ex(t, DA, F_FALL, 0, 15, "rst_fall");
        ex(t, DA, F_PUL, 0, 15, "rst_pulse");
        ex(t, DA, F_FLG, 0, 15, "rst_flag");
        ex(t, DA, F_ANY, 0, 1, "rst_any");
        ex(t, DD, F_LVL, 15, 15, "init1_level");
        for (int i = 0; i < 20; i++) begin
            ex(t + i, DD, F_RISE, 0, 15, "init1_rise");
            ex(t + i, DD, F_FALL, 0, 15, "init1_fall");
            ex(t + i, DD, F_PUL, 0, 15, "init1_pulse");
        end
        tick(2);

        // Basic rise on channel 0: commit five edges after the drive
        t = cyc;
        sig_abc[0] = 1'b1;
        ex(t + 4, DA, F_LVL, 0, 15, "t1_level_pre");
        ex(t + 4, DA, F_RISE, 0, 15, "t1_rise_pre");
        ex(t + 4, DA, F_PUL, 0, 15, "t1_pulse_pre");
        ex(t + 4, DA, F_FLG, 0, 15, "t1_flag_pre");
        ex(t + 5, DA, F_LVL, 1, 15, "t1_level");
        ex(t + 5, DA, F_RISE, 1, 15, "t1_rise");
        ex(t + 5, DA, F_FALL, 0, 15, "t1_fall");
        ex(t + 5, DA, F_PUL, 1, 15, "t1_pulse0");
        ex(t + 5, DA, F_FLG, 1, 15, "t1_flag");
        ex(t + 5, DA, F_ANY, 1, 1, "t1_any");
        ex(t + 6, DA, F_RISE, 0, 15, "t1_rise_once");
        ex(t + 6, DA, F_PUL, 1, 15, "t1_pulse1");
        ex(t + 7, DA, F_PUL, 0, 15, "t1_pulse_end");
        ex(t + 7, DA, F_ANY, 0, 1, "t1_any_end");
        ex(t + 7, DA, F_FLG, 1, 15, "t1_flag_sticky");
        ex(t + 7, DA, F_LVL, 1, 15, "t1_level_hold");
        tick(15);

        // Flag clear alone
        t = cyc;
        ex(t, DA, F_FLG, 1, 1, "t5_flag_before_clr");
        ex(t + 1, DA, F_FLG, 0, 1, "t5_flag_cleared");
        clr_abc[0] = 1'b1;
        tick(1);
        clr_abc[0] = 1'b0;
        tick(2);

        // Falling edge in rising mode leaves the flag alone
        t = cyc;
        sig_abc[0] = 1'b0;
        ex(t + 5, DA, F_FALL, 1, 1, "t5_fall");
        ex(t + 5, DA, F_LVL, 0, 1, "t5_level_low");
        ex(t + 5, DA, F_PUL, 0, 1, "t5_no_pulse_on_fall");
        ex(t + 5, DA, F_FLG, 0, 1, "t5_no_flag_on_fall");
        tick(10);

        // Clear coincident with a rise commit: set wins
        t = cyc;
        sig_abc[0] = 1'b1;
        ex(t + 4, DA, F_FLG, 0, 1, "t5_flag_pre_rise");
        ex(t + 5, DA, F_RISE, 1, 1, "t5_rise_with_clr");
        ex(t + 5, DA, F_FLG, 1, 1, "t5_set_wins");
        ex(t + 6, DA, F_FLG, 1, 1, "t5_set_holds");
        tick(4);
        clr_abc[0] = 1'b1;
        tick(1);
        clr_abc[0] = 1'b0;
        tick(5);

        // Two-cycle glitch on channel 1 is discarded
        t = cyc;
        sig_abc[1] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            ex(t + i, DA, F_LVL, 0, 2, "t2_glitch_level");
            ex(t + i, DA, F_RISE, 0, 2, "t2_glitch_rise");
            ex(t + i, DA, F_PUL, 0, 2, "t2_glitch_pulse");
            ex(t + i, DA, F_FLG, 0, 2, "t2_glitch_flag");
        end
        tick(2);
        sig_abc[1] = 1'b0;
        tick(10);

        // Three-cycle pulse on channel 1 is accepted, fall follows three cycles later
        t = cyc;
        sig_abc[1] = 1'b1;
        ex(t + 4, DA, F_RISE, 0, 2, "t2_rise_pre");
        ex(t + 4, DA, F_LVL, 0, 2, "t2_level_pre");
        ex(t + 5, DA, F_RISE, 2, 2, "t2_rise");
        ex(t + 5, DA, F_LVL, 2, 2, "t2_level_high");
        ex(t + 5, DA, F_PUL, 2, 2, "t2_pulse0");
        ex(t + 5, DA, F_FLG, 2, 2, "t2_flag");
        ex(t + 6, DA, F_RISE, 0, 2, "t2_rise_once");
        ex(t + 6, DA, F_PUL, 2, 2, "t2_pulse1");
        ex(t + 7, DA, F_LVL, 2, 2, "t2_level_still");
        ex(t + 7, DA, F_PUL, 0, 2, "t2_pulse_end");
        ex(t + 7, DA, F_FALL, 0, 2, "t2_fall_pre");
        ex(t + 8, DA, F_FALL, 2, 2, "t2_fall");
        ex(t + 8, DA, F_LVL, 0, 2, "t2_level_low");
        ex(t + 8, DA, F_RISE, 0, 2, "t2_no_rise_on_fall");
        ex(t + 8, DA, F_FLG, 2, 2, "t2_flag_sticky");
        ex(t + 9, DA, F_FALL, 0, 2, "t2_fall_once");
        tick(3);
        sig_abc[1] = 1'b0;
        tick(12);

        // Pulse train on channel 2 across the three edge modes
        t = cyc;
        ex(t + 5, DA, F_RISE, 4, 4, "t3_m0_rise");
        ex(t + 5, DA, F_PUL, 4, 4, "t3_m0_pulse0");
        ex(t + 6, DA, F_PUL, 4, 4, "t3_m0_pulse1");
        ex(t + 7, DA, F_PUL, 0, 4, "t3_m0_pulse_end");
        ex(t + 5, DB, F_PUL, 0, 4, "t3_m1_no_pulse_on_rise");
        ex(t + 20, DB, F_FALL, 4, 4, "t3_m1_fall");
        ex(t + 20, DB, F_PUL, 4, 4, "t3_m1_pulse0");
        ex(t + 21, DB, F_PUL, 4, 4, "t3_m1_pulse1");
        ex(t + 5, DC, F_PUL, 4, 4, "t3_m2_pulse_rise");
        ex(t + 7, DC, F_PUL, 0, 4, "t3_m2_pulse_gap");
        ex(t + 20, DC, F_PUL, 4, 4, "t3_m2_pulse_fall");
        ex(t + 120, DA, F_NRISE, 5, -1, "t3_m0_rise_count");
        ex(t + 120, DA, F_NFALL, 5, -1, "t3_m0_fall_count");
        ex(t + 120, DA, F_NPED, 5, -1, "t3_m0_pulse_count");
        ex(t + 120, DA, F_NPHI, 10, -1, "t3_m0_pulse_cycles");
        ex(t + 120, DB, F_NRISE, 5, -1, "t3_m1_rise_count");
        ex(t + 120, DB, F_NFALL, 5, -1, "t3_m1_fall_count");
        ex(t + 120, DB, F_NPED, 5, -1, "t3_m1_pulse_count");
        ex(t + 120, DB, F_NPHI, 10, -1, "t3_m1_pulse_cycles");
        ex(t + 120, DC, F_NRISE, 5, -1, "t3_m2_rise_count");
        ex(t + 120, DC, F_NFALL, 5, -1, "t3_m2_fall_count");
        ex(t + 120, DC, F_NPED, 10, -1, "t3_m2_pulse_count");
        ex(t + 120, DC, F_NPHI, 20, -1, "t3_m2_pulse_cycles");
        for (int r = 0; r < 5; r++) begin
            sig_abc[2] = 1'b1;
            tick(15);
            sig_abc[2] = 1'b0;
            tick(7);
        end
        tick(15);

        // Retriggered long pulse on channel 3 of the FILTER=1 instance
        t = cyc;
        for (int i = 2; i <= 20; i++) begin
            ex(t + i, DD, F_PUL, (i >= 3 && i <= 19) ? 8 : 0, 8, "t4_pulse_merge");
            ex(t + i, DD, F_ANY, (i >= 3 && i <= 19) ? 1 : 0, 1, "t4_any_pulse");
        end
        ex(t + 3, DD, F_FALL, 8, 8, "t4_fall0");
        ex(t + 3, DD, F_RISE, 0, 8, "t4_no_rise0");
        ex(t + 4, DD, F_FALL, 0, 8, "t4_fall_once");
        ex(t + 4, DD, F_LVL, 0, 8, "t4_level_low");
        ex(t + 6, DD, F_RISE, 8, 8, "t4_rise1");
        ex(t + 9, DD, F_FALL, 8, 8, "t4_fall2");
        ex(t + 12, DD, F_RISE, 8, 8, "t4_rise3");
        ex(t + 12, DD, F_FLG, 8, 8, "t4_flag");
        sig_d[3] = 1'b0;
        tick(3);
        sig_d[3] = 1'b1;
        tick(3);
        sig_d[3] = 1'b0;
        tick(3);
        sig_d[3] = 1'b1;
        tick(13);

        // Asynchronous reset in the middle of a pulse
        t = cyc;
        sig_abc[3] = 1'b1;
        ex(t + 5, DA, F_PUL, 8, 8, "t6_pulse_before_rst");
        ex(t + 5, DA, F_FLG, 8, 8, "t6_flag_before_rst");
        ex(t + 5, DA, F_LVL, 8, 8, "t6_level_before_rst");
        ex(t + 6, DA, F_PUL, 0, 15, "t6_pulse_async_clear");
        ex(t + 6, DA, F_FLG, 0, 15, "t6_flag_async_clear");
        ex(t + 6, DA, F_LVL, 0, 15, "t6_level_async_clear");
        ex(t + 6, DA, F_ANY, 0, 1, "t6_any_async_clear");
        ex(t + 6, DD, F_FLG, 0, 15, "t6_init1_flag_clear");
        ex(t + 6, DD, F_LVL, 15, 15, "t6_init1_level");
        tick(6);
        #1;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;

        // No events after release with the INIT_LEVEL=1 instance held high
        t = cyc;
        for (int i = 0; i < 20; i++) begin
            ex(t + i, DD, F_RISE, 0, 15, "t6_quiet_rise");
            ex(t + i, DD, F_FALL, 0, 15, "t6_quiet_fall");
            ex(t + i, DD, F_PUL, 0, 15, "t6_quiet_pulse");
        end
        tick(22);

        for (int i = 0; i < 300 && q.size() != 0; i++) tick(1);
        if (q.size() != 0) begin
            $display("FAIL drain: %0d expectations never retired", q.size());
            $fatal(1, "scoreboard did not drain");
        end
        tick(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
